mem_bist_array: RTL and testbench

- Parametrised on-chip memory array: word-addressed, single port, synchronous write, registered read.
- Adds a built-in March C- self-test engine and a deterministic stuck-at-0 fault-injection hook.
- Intended as the next-generation memory-under-test core behind the tile's pin-level top.
- The top maps the manual port to pins and exposes BIST status.

---
 rtl/mem_bist_array.sv | 93 +++++++++
 tb/tb_mem_bist_array.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_array.sv
// mem_bist_array: single-port memory with March C- self-test engine and stuck-at-0 fault hook
module mem_bist_array #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 8,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata,
    input  logic                 bist_start,
    input  logic [DATA_BITS-1:0] bist_bg,
    output logic                 bist_busy,
    output logic                 bist_done,
    output logic                 bist_fail,
    output logic [ADDR_BITS-1:0] bist_fail_addr,
    output logic [CNT_BITS-1:0]  bist_fail_count,
    input  logic                 fi_en,
    input  logic [ADDR_BITS-1:0] fi_addr
);
    localparam int DEPTH = 1 << ADDR_BITS;
    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_BITS-1:0] ptr, ptr_n, a;
    logic [DATA_BITS-1:0] bg, d, exp_val;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic phase, phase_n, down, last, check, mem_we, mismatch;
    // march sequencing, port mux and compare; phase 1 is the compare/write half of an address
    always_comb begin
        bist_busy = !(state inside {IDLE, DONE});
        bist_done = state == DONE;
        down      = state inside {M3, M4, M5};
        last      = down ? ptr == '0 : ptr == '1;
        check     = bist_busy && state != M0 && phase;
        exp_val   = (state inside {M1, M3, M5}) ? bg : ~bg;
        d         = bist_busy ? ((state inside {M0, M2, M4}) ? bg : ~bg) : wdata;
        a         = bist_busy ? ptr : addr;
        mem_we    = rst_n && (bist_busy ? (state == M0 || (check && state != M5)) : we);
        mismatch  = check && rdata != exp_val;
        state_n   = state;
        ptr_n     = ptr;
        phase_n   = phase;
        if (state == IDLE) begin
            state_n = bist_start ? M0 : IDLE;
            ptr_n   = '0;
            phase_n = 1'b0;
        end else if (state == DONE) begin
            state_n = IDLE;
        end else begin
            phase_n = state != M0 && !phase;
            if (state == M0 || phase) begin
                ptr_n = down ? ptr - 1'b1 : ptr + 1'b1;
                if (last) begin
                    state_n = state_t'(state + 3'd1);
                    ptr_n   = state == M2 ? ptr : ptr_n;
                end
            end
        end
    end
    // state, read register and sticky fail tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            phase           <= 1'b0;
            rdata           <= '0;
            bist_fail       <= 1'b0;
            bist_fail_addr  <= '0;
            bist_fail_count <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            phase <= phase_n;
            rdata <= mem[a];
            if (state == IDLE && bist_start) begin
                bg              <= bist_bg;
                bist_fail       <= 1'b0;
                bist_fail_addr  <= '0;
                bist_fail_count <= '0;
            end else if (mismatch) begin
                bist_fail <= 1'b1;
                if (!bist_fail) bist_fail_addr <= ptr;
                if (bist_fail_count != '1) bist_fail_count <= bist_fail_count + 1'b1;
            end
        end
    end
    // array write; the faulty word loses bit 0 on every write
    always_ff @(posedge clk) begin
        if (mem_we) mem[a] <= (fi_en && a == fi_addr) ? {d[DATA_BITS-1:1], 1'b0} : d;
    end
endmodule

// File: tb/tb_mem_bist_array.sv
// tb_mem_bist_array: randomized scoreboard bench for mem_bist_array against an array-level March C- model
module tb_mem_bist_array;
    localparam int AB = 5;
    localparam int DB = 8;
    localparam int DEPTH = 32;
    localparam int BUSY_CYC = 11 * DEPTH;
    typedef struct {int fail; int fa; int cnt; int scnt;} res_t;
    logic clk = 0, rst_n = 0, we = 0, bist_start = 0, fi_en = 0, rd_tag = 0;
    logic [AB-1:0] addr = '0, fi_addr = '0;
    logic [DB-1:0] wdata = '0, bist_bg = '0;
    logic [DB-1:0] rdata, s_rdata;
    logic bist_busy, bist_done, bist_fail, s_busy, s_done, s_fail;
    logic [AB-1:0] bist_fail_addr, s_fail_addr;
    logic [7:0] bist_fail_count;
    logic [0:0] s_count;
    logic [DB-1:0] ref_mem [DEPTH];
    logic [DB-1:0] rq [$];
    res_t bq [$];
    int total = 0, bad = 0, done_seen = 0, bc = 0, sbc = 0;
    logic tag_s, rst_s, pd = 0;
    logic [DB-1:0] e;
    res_t r;

    mem_bist_array #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .bist_start(bist_start), .bist_bg(bist_bg), .bist_busy(bist_busy), .bist_done(bist_done),
        .bist_fail(bist_fail), .bist_fail_addr(bist_fail_addr), .bist_fail_count(bist_fail_count),
        .fi_en(fi_en), .fi_addr(fi_addr)
    );
    mem_bist_array #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata), .rdata(s_rdata),
        .bist_start(bist_start), .bist_bg(bist_bg), .bist_busy(s_busy), .bist_done(s_done),
        .bist_fail(s_fail), .bist_fail_addr(s_fail_addr), .bist_fail_count(s_count),
        .fi_en(fi_en), .fi_addr(fi_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void store(int a, logic [DB-1:0] v);
        ref_mem[a] = (fi_en && a == int'(fi_addr)) ? (v & 8'hFE) : v;
    endfunction

    // March C- on the reference array: w P; up r P w ~P; up r ~P w P; down r P w ~P; down r ~P w P; down r P
    function automatic res_t model(logic [DB-1:0] p);
        res_t o;
        logic [DB-1:0] rx [5];
        logic [DB-1:0] wv [4];
        int n = 0, fa = 0, a;
        rx = '{p, ~p, p, ~p, p};
        wv = '{~p, p, ~p, p};
        for (int k = 0; k < DEPTH; k++) store(k, p);
        for (int el = 0; el < 5; el++)
            for (int k = 0; k < DEPTH; k++) begin
                a = el >= 2 ? DEPTH - 1 - k : k;
                if (ref_mem[a] != rx[el]) begin
                    if (n == 0) fa = a;
                    n++;
                end
                if (el < 4) store(a, wv[el]);
            end
        o.fail = n > 0;
        o.fa = fa;
        o.cnt = n > 255 ? 255 : n;
        o.scnt = n > 1 ? 1 : n;
        return o;
    endfunction

    task automatic cycle(logic w, int a, logic [DB-1:0] dv, logic rd);
        @(negedge clk);
        we = w;
        addr = AB'(a);
        wdata = dv;
        rd_tag = rd;
        if (rd) rq.push_back(ref_mem[a]);
        if (w) store(a, dv);
    endtask

    task automatic readback();
        for (int a = 0; a < DEPTH; a++) cycle(0, a, 0, 1);
        cycle(0, 0, 0, 0);
    endtask

    task automatic run_bist(logic [DB-1:0] bg, logic fe, logic [AB-1:0] fa, int abort_at);
        int d0;
        bit seen = 0;
        @(negedge clk);
        bist_bg = bg;
        fi_en = fe;
        fi_addr = fa;
        bist_start = 1;
        we = 0;
        rd_tag = 0;
        if (abort_at == 0) bq.push_back(model(bg));
        d0 = done_seen;
        for (int i = 1; i < 600; i++) begin
            @(negedge clk);
            if (bist_done) begin
                seen = 1;
                break;
            end
            if (i == abort_at) begin
                chk("fail_before_abort", int'(bist_fail), 1);
                rst_n = 0;
                bist_start = 0;
                we = 0;
                @(negedge clk);
                chk("abort_busy", int'(bist_busy), 0);
                chk("abort_fail", int'(bist_fail), 0);
                chk("abort_count", int'(bist_fail_count), 0);
                rst_n = 1;
                repeat (3) @(negedge clk);
                chk("abort_no_done", done_seen - d0, 0);
                return;
            end
            bist_start = (i < 300) && ($urandom_range(0, 7) == 0);
            we = 1'($urandom);
            addr = AB'($urandom);
            wdata = DB'($urandom);
        end
        bist_start = 0;
        we = 0;
        chk("done_seen", int'(seen), 1);
    endtask

    // monitor: pops expected read data and BIST results whenever the DUT presents them
    initial begin
        forever begin
            @(posedge clk);
            tag_s = rd_tag;
            rst_s = rst_n;
            #1;
            if (tag_s) begin
                if (rq.size() == 0) chk("rdq_underflow", 0, 1);
                else begin
                    e = rq.pop_front();
                    chk("rdata", int'(rdata), int'(e));
                    chk("rdata_sat", int'(s_rdata), int'(e));
                end
            end
            if (!rst_s) begin
                bc = 0;
                sbc = 0;
            end else begin
                bc += int'(bist_busy);
                sbc += int'(s_busy);
            end
            if (bist_done) begin
                done_seen++;
                chk("done_width", int'(pd), 0);
                if (bq.size() == 0) chk("bq_underflow", 0, 1);
                else begin
                    r = bq.pop_front();
                    chk("busy_cycles", bc, BUSY_CYC);
                    chk("sat_busy_cycles", sbc, BUSY_CYC);
                    chk("sat_done", int'(s_done), 1);
                    chk("fail", int'(bist_fail), r.fail);
                    chk("fail_addr", int'(bist_fail_addr), r.fa);
                    chk("fail_count", int'(bist_fail_count), r.cnt);
                    chk("sat_fail", int'(s_fail), r.fail);
                    chk("sat_fail_addr", int'(s_fail_addr), r.fa);
                    chk("sat_count", int'(s_count), r.scnt);
                end
                bc = 0;
                sbc = 0;
            end
            pd = bist_done;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DB-1:0] bgs [4];
        logic [AB-1:0] fas [4];
        logic fes [4];
        bgs = '{8'h00, 8'h00, 8'hFF, 8'h00};
        fes = '{1'b0, 1'b1, 1'b1, 1'b1};
        fas = '{5'd0, 5'd5, 5'd9, 5'd0};
        repeat (2) @(negedge clk);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_busy", int'(bist_busy), 0);
        chk("rst_done", int'(bist_done), 0);
        chk("rst_fail", int'(bist_fail), 0);
        chk("rst_fail_addr", int'(bist_fail_addr), 0);
        chk("rst_count", int'(bist_fail_count), 0);
        rst_n = 1;
        for (int a = 0; a < DEPTH; a++) cycle(1, a, DB'($urandom), 0);
        cycle(1, 3, 8'hA5, 0);
        cycle(1, 31, 8'h3C, 0);
        cycle(0, 3, 0, 1);
        cycle(0, 31, 0, 1);
        cycle(1, 3, 8'h5A, 1);
        cycle(0, 3, 0, 1);
        cycle(0, 0, 0, 0);
        fi_en = 1'($urandom);
        fi_addr = AB'($urandom);
        for (int i = 0; i < 200; i++) cycle(1'($urandom), $urandom_range(0, DEPTH - 1), DB'($urandom), 1'($urandom));
        cycle(0, 0, 0, 0);
        readback();
        for (int t = 0; t < 4; t++) begin
            run_bist(bgs[t], fes[t], fas[t], 0);
            readback();
        end
        run_bist(8'hFF, 1'b1, 5'd9, 100);
        run_bist(8'h00, 1'b0, 5'd0, 0);
        readback();
        for (int t = 0; t < 3; t++) begin
            run_bist(DB'($urandom), 1'($urandom), AB'($urandom), 0);
            readback();
        end
        repeat (5) @(negedge clk);
        chk("rq_empty", rq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
